// File: rtl/riscv_mtimer.sv
// ============================================================================
// riscv_mtimer
// ----------------------------------------------------------------------------
// Memory-mapped machine timer. Holds a 64-bit mtime counter advanced by a
// programmable prescaler, a 64-bit mtimecmp compare value, and raises the
// level interrupt t_intr_o while the timer is enabled and mtime >= mtimecmp.
//
// Register map (byte offsets, addr_i[1:0] ignored):
//   0x00 MTIME_LO     0x04 MTIME_HI
//   0x08 MTIMECMP_LO  0x0C MTIMECMP_HI
//   0x10 CTRL   bit0 EN, bits[8+PRESCALE_W-1:8] DIV, other bits read 0
//   0x14 STATUS bit0 raw compare (mtime >= mtimecmp), read-only
//   other offsets read 0, writes ignored
//
// Ports:
//   clk_i     clock
//   rst_i     synchronous active-high reset
//   req_i     bus access request, one cycle per access
//   we_i      1 = write, 0 = read (qualified by req_i)
//   addr_i    byte address
//   wdata_i   write data (full-word writes)
//   rdata_o   registered read data (0 after a write beat)
//   rvalid_o  high one cycle after every req_i
//   t_intr_o  timer interrupt level
//
// Optional feature (macro RISCV_MTIMER_HI_LATCH_EN):
//   A read of MTIME_LO snapshots mtime[63:32] into a shadow register and
//   MTIME_HI reads return that shadow, making a lo-then-hi read pair coherent
//   across a carry. Without the macro MTIME_HI reads return live mtime[63:32].
// ============================================================================
module riscv_mtimer #(
   parameter int DW         = 32,
   parameter int ADDRW      = 12,
   parameter int PRESCALE_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req_i,
   input  logic             we_i,
   input  logic [ADDRW-1:0] addr_i,
   input  logic [DW-1:0]    wdata_i,
   output logic [DW-1:0]    rdata_o,
   output logic             rvalid_o,
   output logic             t_intr_o
);

   localparam int WIDX_W = ADDRW - 2;

   localparam logic [WIDX_W-1:0] IDX_MTIME_LO = WIDX_W'(0);
   localparam logic [WIDX_W-1:0] IDX_MTIME_HI = WIDX_W'(1);
   localparam logic [WIDX_W-1:0] IDX_CMP_LO   = WIDX_W'(2);
   localparam logic [WIDX_W-1:0] IDX_CMP_HI   = WIDX_W'(3);
   localparam logic [WIDX_W-1:0] IDX_CTRL     = WIDX_W'(4);
   localparam logic [WIDX_W-1:0] IDX_STATUS   = WIDX_W'(5);

   // Architectural state
   logic [63:0]           mtime;
   logic [63:0]           mtimecmp;
   logic                  en;
   logic [PRESCALE_W-1:0] div;
   logic [PRESCALE_W-1:0] pcnt;

   // Decode
   logic [WIDX_W-1:0] widx;
   logic              bus_wr;
   logic              bus_rd;
   logic              wr_mtime_lo;
   logic              wr_mtime_hi;
   logic              wr_cmp_lo;
   logic              wr_cmp_hi;
   logic              wr_ctrl;
   logic              unused_addr_lsb;

   assign widx            = addr_i[ADDRW-1:2];
   assign unused_addr_lsb = ^addr_i[1:0];
   assign bus_wr          = req_i & we_i;
   assign bus_rd          = req_i & ~we_i;
   assign wr_mtime_lo     = bus_wr && (widx == IDX_MTIME_LO);
   assign wr_mtime_hi     = bus_wr && (widx == IDX_MTIME_HI);
   assign wr_cmp_lo       = bus_wr && (widx == IDX_CMP_LO);
   assign wr_cmp_hi       = bus_wr && (widx == IDX_CMP_HI);
   assign wr_ctrl         = bus_wr && (widx == IDX_CTRL);

   // Prescaler and counter next-state
   logic                  tick;
   logic [63:0]           mtime_inc;
   logic [63:0]           mtime_nxt;
   logic [PRESCALE_W-1:0] pcnt_nxt;
   logic                  cmp_hit;

   assign tick      = en && (pcnt == div);
   assign mtime_inc = mtime + 64'(tick);
   assign cmp_hit   = (mtime >= mtimecmp);

   // A write replaces only the addressed half; the other half keeps its
   // incremented value so a carry out of the low half is never lost.
   always_comb begin
      mtime_nxt = mtime_inc;
      if (wr_mtime_lo) mtime_nxt[31:0]  = wdata_i[31:0];
      if (wr_mtime_hi) mtime_nxt[63:32] = wdata_i[31:0];
   end

   always_comb begin
      if (wr_ctrl || !en || tick) pcnt_nxt = '0;
      else                        pcnt_nxt = pcnt + PRESCALE_W'(1);
   end

   // Read mux
   logic [DW-1:0] ctrl_rd;
   logic [31:0]   mtime_hi_rd;
   logic [DW-1:0] rd_val;

   always_comb begin
      ctrl_rd                  = '0;
      ctrl_rd[0]               = en;
      ctrl_rd[8 +: PRESCALE_W] = div;
   end

`ifdef RISCV_MTIMER_HI_LATCH_EN
   logic [31:0] mtime_hi_shadow;

   // Shadow captures the pre-edge high word on every MTIME_LO read.
   always_ff @(posedge clk_i) begin
      if (rst_i)
         mtime_hi_shadow <= '0;
      else if (bus_rd && (widx == IDX_MTIME_LO))
         mtime_hi_shadow <= mtime[63:32];
   end

   assign mtime_hi_rd = mtime_hi_shadow;
`else
   assign mtime_hi_rd = mtime[63:32];
`endif

   always_comb begin
      rd_val = '0;
      case (widx)
         IDX_MTIME_LO: rd_val = mtime[31:0];
         IDX_MTIME_HI: rd_val = mtime_hi_rd;
         IDX_CMP_LO:   rd_val = mtimecmp[31:0];
         IDX_CMP_HI:   rd_val = mtimecmp[63:32];
         IDX_CTRL:     rd_val = ctrl_rd;
         IDX_STATUS:   rd_val = DW'(cmp_hit);
         default:      rd_val = '0;
      endcase
   end

   // State update
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mtime    <= '0;
         mtimecmp <= '1;
         en       <= 1'b0;
         div      <= '0;
         pcnt     <= '0;
         rdata_o  <= '0;
         rvalid_o <= 1'b0;
         t_intr_o <= 1'b0;
      end else begin
         mtime    <= mtime_nxt;
         pcnt     <= pcnt_nxt;
         rvalid_o <= req_i;
         // Compare uses register values, giving one cycle of latency.
         t_intr_o <= en && cmp_hit;

         if (wr_cmp_lo) mtimecmp[31:0]  <= wdata_i[31:0];
         if (wr_cmp_hi) mtimecmp[63:32] <= wdata_i[31:0];
         if (wr_ctrl) begin
            en  <= wdata_i[0];
            div <= wdata_i[8 +: PRESCALE_W];
         end

         if (bus_rd)      rdata_o <= rd_val;
         else if (bus_wr) rdata_o <= '0;
      end
   end

endmodule

// File: tb/tb_riscv_mtimer.sv
module tb_riscv_mtimer;

   localparam logic [11:0] A_MLO  = 12'h000;
   localparam logic [11:0] A_MHI  = 12'h004;
   localparam logic [11:0] A_CLO  = 12'h008;
   localparam logic [11:0] A_CHI  = 12'h00C;
   localparam logic [11:0] A_CTRL = 12'h010;
   localparam logic [11:0] A_STAT = 12'h014;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        req_i = 1'b0;
   logic        we_i = 1'b0;
   logic [11:0] addr_i = '0;
   logic [31:0] wdata_i = '0;
   logic [31:0] rdata_o;
   logic        rvalid_o;
   logic        t_intr_o;

   int checks = 0;
   int errors = 0;

   riscv_mtimer #(.DW(32), .ADDRW(12), .PRESCALE_W(8)) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .req_i    (req_i),
      .we_i     (we_i),
      .addr_i   (addr_i),
      .wdata_i  (wdata_i),
      .rdata_o  (rdata_o),
      .rvalid_o (rvalid_o),
      .t_intr_o (t_intr_o)
   );

   always #5 clk_i = ~clk_i;

   // ---------------- behavioural reference model ----------------
   // Ticks are derived from the number of enabled cycles since the last
   // CTRL write: a tick happens whenever that count mod (DIV+1) equals DIV.
   logic [63:0] m_time;
   logic [63:0] m_cmp;
   logic        m_en;
   logic [7:0]  m_div;
   int          m_phase;
   logic [31:0] m_shadow;
   logic [31:0] e_rdata;
   logic        e_rvalid;
   logic        e_intr;

   function automatic logic [31:0] model_read(input logic [11:0] a);
      logic [9:0] w;
      w = a[11:2];
      case (w)
         10'd0: return m_time[31:0];
`ifdef RISCV_MTIMER_HI_LATCH_EN
         10'd1: return m_shadow;
`else
         10'd1: return m_time[63:32];
`endif
         10'd2: return m_cmp[31:0];
         10'd3: return m_cmp[63:32];
         10'd4: return {16'h0, m_div, 7'h0, m_en};
         10'd5: return {31'h0, (m_time >= m_cmp)};
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_step();
      logic        tk;
      logic [63:0] t;
      logic [9:0]  w;
      if (rst_i) begin
         m_time = 64'h0; m_cmp = {64{1'b1}}; m_en = 1'b0; m_div = 8'h0;
         m_phase = 0; m_shadow = 32'h0;
         e_rdata = 32'h0; e_rvalid = 1'b0; e_intr = 1'b0;
      end else begin
         w  = addr_i[11:2];
         tk = m_en && ((m_phase % (int'(m_div) + 1)) == int'(m_div));
         e_intr   = m_en && (m_time >= m_cmp);
         e_rvalid = req_i;
         if (req_i && !we_i) e_rdata = model_read(addr_i);
         else if (req_i)     e_rdata = 32'h0;
`ifdef RISCV_MTIMER_HI_LATCH_EN
         if (req_i && !we_i && w == 10'd0) m_shadow = m_time[63:32];
`endif
         if (m_en) m_phase = m_phase + 1;
         t = m_time + (tk ? 64'd1 : 64'd0);
         if (req_i && we_i) begin
            case (w)
               10'd0: t[31:0] = wdata_i;
               10'd1: t[63:32] = wdata_i;
               10'd2: m_cmp[31:0] = wdata_i;
               10'd3: m_cmp[63:32] = wdata_i;
               10'd4: begin m_en = wdata_i[0]; m_div = wdata_i[15:8]; m_phase = 0; end
               default: ;
            endcase
         end
         m_time = t;
      end
   endtask

   // ---------------- bus drivers ----------------
   task automatic cyc(input logic r, input logic q, input logic w,
                      input logic [11:0] a, input logic [31:0] d);
      rst_i = r; req_i = q; we_i = w; addr_i = a; wdata_i = d;
      @(posedge clk_i);
      model_step();
      #1;
      rst_i = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      cyc(1'b0, 1'b1, 1'b1, a, d);
   endtask

   task automatic rd(input logic [11:0] a);
      cyc(1'b0, 1'b1, 1'b0, a, 32'h0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [31:0] exp_v [6];
      logic [11:0] offs [6];
      exp_v = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0};
      offs  = '{A_MLO, A_MHI, A_CLO, A_CHI, A_CTRL, A_STAT};
      cyc(1'b1, 1'b0, 1'b0, 12'h0, 32'h0);
      cyc(1'b1, 1'b0, 1'b0, 12'h0, 32'h0);
      checks++;
      if (rvalid_o !== 1'b0 || t_intr_o !== 1'b0 || rdata_o !== 32'h0) begin
         errors++;
         $display("FAIL reset_state rvalid=%b intr=%b rdata=%h want 0/0/0", rvalid_o, t_intr_o, rdata_o);
      end
      for (int i = 0; i < 6; i++) begin
         rd(offs[i]);
         checks++;
         if (rdata_o !== exp_v[i] || rvalid_o !== 1'b1 || t_intr_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_read off=%h got %h rv=%b intr=%b want %h rv=1 intr=0",
                     offs[i], rdata_o, rvalid_o, t_intr_o, exp_v[i]);
         end
      end
      idle(1);
      checks++;
      if (rvalid_o !== 1'b0) begin
         errors++;
         $display("FAIL rvalid_idle got %b want 0", rvalid_o);
      end
   endtask

   task automatic test_compare_irq();
      wr(A_CHI, 32'h0);
      wr(A_CLO, 32'd20);
      wr(A_CTRL, 32'h1);
      for (int k = 1; k <= 25; k++) begin
         idle(1);
         checks++;
         if (t_intr_o !== (k >= 21) || t_intr_o !== e_intr) begin
            errors++;
            $display("FAIL irq_rise k=%0d got %b want %b", k, t_intr_o, (k >= 21));
         end
      end
   endtask

   task automatic test_cmp_rewrite();
      wr(A_CLO, 32'hFFFF_FFFF);
      checks++;
      if (t_intr_o !== 1'b1) begin
         errors++;
         $display("FAIL irq_hold_after_write got %b want 1", t_intr_o);
      end
      idle(1);
      checks++;
      if (t_intr_o !== 1'b0) begin
         errors++;
         $display("FAIL irq_fall got %b want 0", t_intr_o);
      end
      rd(A_STAT);
      checks++;
      if (rdata_o !== 32'h0 || rdata_o !== e_rdata) begin
         errors++;
         $display("FAIL status_clear got %h want 0", rdata_o);
      end
   endtask

   task automatic test_prescale();
      wr(A_CTRL, 32'h0);
      wr(A_MLO, 32'h0);
      wr(A_MHI, 32'h0);
      wr(A_CTRL, 32'h0000_0301);
      idle(40);
      rd(A_MLO);
      checks++;
      if (rdata_o !== 32'd10 || rdata_o !== e_rdata) begin
         errors++;
         $display("FAIL prescale_div3 got %0d want 10", rdata_o);
      end
      rd(A_CTRL);
      checks++;
      if (rdata_o !== 32'h0000_0301) begin
         errors++;
         $display("FAIL ctrl_readback got %h want 00000301", rdata_o);
      end
      wr(A_CTRL, 32'h0);
      idle(7);
      rd(A_MLO);
      checks++;
      if (rdata_o !== 32'd10) begin
         errors++;
         $display("FAIL frozen got %0d want 10", rdata_o);
      end
   endtask

   task automatic test_carry_latch();
      wr(A_CTRL, 32'h0);
      wr(A_MLO, 32'hFFFF_FFFE);
      wr(A_MHI, 32'd5);
      wr(A_CTRL, 32'h1);
      idle(1);
      rd(A_MLO);
      checks++;
      if (rdata_o !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL carry_lo got %h want ffffffff", rdata_o);
      end
      rd(A_MHI);
      checks++;
`ifdef RISCV_MTIMER_HI_LATCH_EN
      if (rdata_o !== 32'd5) begin
         errors++;
         $display("FAIL carry_hi_latched got %0d want 5", rdata_o);
      end
`else
      if (rdata_o !== 32'd6) begin
         errors++;
         $display("FAIL carry_hi_live got %0d want 6", rdata_o);
      end
`endif
      wr(A_CTRL, 32'h0);
      rd(A_MLO);
      rd(A_MHI);
      checks++;
      if (rdata_o !== 32'd6) begin
         errors++;
         $display("FAIL carry_hi_after got %0d want 6", rdata_o);
      end
   endtask

   task automatic test_write_tick();
      wr(A_CTRL, 32'h0);
      wr(A_MLO, 32'hFFFF_FFFE);
      wr(A_MHI, 32'd7);
      wr(A_CTRL, 32'h1);
      idle(1);
      wr(A_MLO, 32'd100);
      checks++;
      if (rdata_o !== 32'h0 || rvalid_o !== 1'b1) begin
         errors++;
         $display("FAIL write_beat_rdata got %h rv=%b want 0 rv=1", rdata_o, rvalid_o);
      end
      rd(A_MLO);
      checks++;
      if (rdata_o !== 32'd100) begin
         errors++;
         $display("FAIL write_tick_lo got %0d want 100", rdata_o);
      end
      rd(A_MHI);
      checks++;
      if (rdata_o !== 32'd8) begin
         errors++;
         $display("FAIL write_tick_carry got %0d want 8", rdata_o);
      end
   endtask

   task automatic test_reset_midaccess();
      wr(A_CHI, 32'h0);
      wr(A_CLO, 32'h0);
      idle(2);
      checks++;
      if (t_intr_o !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_irq got %b want 1", t_intr_o);
      end
      cyc(1'b1, 1'b1, 1'b0, A_MLO, 32'h0);
      checks++;
      if (rvalid_o !== 1'b0 || rdata_o !== 32'h0 || t_intr_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_midaccess rv=%b rdata=%h intr=%b want 0/0/0", rvalid_o, rdata_o, t_intr_o);
      end
      rd(A_CLO);
      checks++;
      if (rdata_o !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL reset_cmp got %h want ffffffff", rdata_o);
      end
      rd(A_CTRL);
      checks++;
      if (rdata_o !== 32'h0) begin
         errors++;
         $display("FAIL reset_ctrl got %h want 0", rdata_o);
      end
   endtask

   task automatic test_random();
      logic        q, w, r;
      logic [9:0]  idx;
      logic [31:0] d;
      for (int n = 0; n < 600; n++) begin
         r   = ($urandom_range(0, 149) == 0);
         q   = ($urandom_range(0, 3) != 0);
         w   = $urandom_range(0, 1);
         idx = ($urandom_range(0, 9) == 0) ? 10'($urandom) : 10'($urandom_range(0, 7));
         d   = $urandom;
         case (idx)
            10'd1, 10'd3: if ($urandom_range(0, 3) != 0) d = 32'h0;
            10'd2:        d = $urandom_range(0, 400);
            10'd4:        d = (d & 32'hFFFF_00FE) | {22'h0, 2'($urandom_range(0, 3)), 7'h0, 1'($urandom_range(0, 4) != 0)};
            default: ;
         endcase
         cyc(r, q, w, {idx, 2'($urandom)}, d);
         checks++;
         if (rdata_o !== e_rdata || rvalid_o !== e_rvalid || t_intr_o !== e_intr) begin
            errors++;
            $display("FAIL random n=%0d rdata=%h rv=%b intr=%b want %h/%b/%b",
                     n, rdata_o, rvalid_o, t_intr_o, e_rdata, e_rvalid, e_intr);
         end
      end
   endtask

   initial begin
      test_reset();
      test_compare_irq();
      test_cmp_rewrite();
      test_prescale();
      test_carry_latch();
      test_write_tick();
      test_reset_midaccess();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/riscv_mtimer.md
Name: riscv_mtimer

Overview:
Memory-mapped machine timer that produces the timer interrupt `t_intr` consumed by the pipelined core's CSR unit. It sets MIP.MTIP whenever `t_intr` is high.
- Holds a 64-bit mtime counter, a 64-bit mtimecmp compare value and a prescaler.
- Software reaches it through a simple single-cycle word bus driven from the memory stage's data-memory decode.
- The output is a level interrupt. It stays high until software rewrites mtimecmp or disables the timer.

Parameters:
- DW, 32, bus data width; only 32 is supported.
- ADDRW, 12, bus address width (byte address).
- PRESCALE_W, 8, width of the prescaler divide field.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- req_i  in  1  bus access request, one cycle per access
- we_i  in  1  1 = write, 0 = read; qualified by req_i
- addr_i  in  ADDRW  byte address; bits [1:0] ignored
- wdata_i  in  DW  write data, full-word writes only
- rdata_o  out  DW  read data, registered
- rvalid_o  out  1  high exactly one cycle after every req_i, for both reads and writes
- t_intr_o  out  1  timer interrupt level, connects to the core's t_intr

Behaviour:
- Register map, offsets within ADDRW:
  - 0x00 MTIME_LO
  - 0x04 MTIME_HI
  - 0x08 MTIMECMP_LO
  - 0x0C MTIMECMP_HI
  - 0x10 CTRL: bit0 EN; bits[8+PRESCALE_W-1:8] DIV; all other bits read 0
  - 0x14 STATUS: bit0 = raw compare result (mtime >= mtimecmp); read-only
- Reset values: mtime = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, CTRL = 0, prescale count = 0, rdata_o = 0, rvalid_o = 0, t_intr_o = 0.
- Prescaler, active only while EN = 1:
  - pcnt increments each cycle.
  - When pcnt == DIV, a tick occurs and pcnt returns to 0.
  - DIV = 0 gives a tick every cycle.
  - With EN = 0, pcnt holds at 0 and mtime is frozen.
- Writes to CTRL reset pcnt to 0 in the same cycle.
- Tick: mtime <= mtime + 1 as a full 64-bit add. It wraps from all-ones to 0 with no flag.
- Bus write, taking effect at the clock edge where req_i && we_i:
  - The addressed register updates.
  - Write beats tick for the addressed half of mtime.
  - The unaddressed half takes its normal next value, including carry out of the low half if that tick carried.
- Writes to STATUS or unmapped offsets have no effect.
- Bus read:
  - rdata_o is loaded at the edge where req_i && !we_i.
  - The loaded value is the register contents before that edge's updates.
  - Unmapped offsets read 0.
  - On a write cycle, rdata_o is loaded with 0.
- rvalid_o <= req_i every cycle. There is no back-pressure and requests may arrive back-to-back.
- Interrupt:
  - t_intr_o <= EN && (mtime >= mtimecmp), unsigned 64-bit compare on register values.
  - This gives one cycle of latency after the condition becomes true or false.
  - Rewriting mtimecmp above mtime deasserts t_intr_o on the second edge after the write.
- A reset in mid-operation, including mid-access, returns everything to reset values at that edge. rvalid_o is 0 in the following cycle regardless of req_i.

Optional Feature:
- Macro RISCV_MTIMER_HI_LATCH_EN.
- Defined:
  - A read of MTIME_LO also snapshots mtime[63:32] into a shadow register.
  - A read of MTIME_HI returns the shadow, so a lo-then-hi read pair is coherent across carry.
  - The shadow resets to 0.
  - Writes to MTIME_HI do not update the shadow.
- Undefined: no shadow register; MTIME_HI reads return live mtime[63:32].

Test Plan:
- Reset, then read all six offsets -> MTIME 0/0, MTIMECMP FFFFFFFF/FFFFFFFF, CTRL 0, STATUS 0; rvalid_o high one cycle after each req; t_intr_o 0.
- Write MTIMECMP_HI = 0 and MTIMECMP_LO = 20, then CTRL = 0x1 (DIV 0) -> mtime counts 1 per cycle; t_intr_o rises one cycle after mtime reaches 20, i.e. 21 cycles after the EN write edge, and stays high.
- With the interrupt pending, write MTIMECMP_LO = 0xFFFF_FFFF -> t_intr_o low two edges after the write, and STATUS bit0 reads 0.
- CTRL = 0x0301 (DIV 3) -> mtime increments every 4 cycles; after 40 cycles mtime = 10; writing CTRL = 0 freezes mtime.
- Preload MTIME_LO = 0xFFFF_FFFE and MTIME_HI = 5 with EN, DIV 0 -> after two ticks MTIME_HI = 6 and MTIME_LO = 0. Then:
  - Defined: a lo read at 0xFFFF_FFFF followed by a hi read returns 5.
  - Undefined: the same read pair returns 6.
- A write to MTIME_LO of 100 coincident with a tick -> mtime = 100 on the next cycle, with no increment lost to the high half; req_i with rst_i in the same cycle -> rvalid_o 0 next cycle, all registers at reset values.
